// File: rtl/cmul_pkg.sv
// Shared definitions for the sequenced complex multiplier controller.
//   W        operand width (fixed at 32 by the shared vedic32 multiplier)
//   PW       product / result width
//   state_e  controller sequence: IDLE -> MUL0..MUL3 -> (DRAIN) -> DONE
// Build option: CMUL_SEQ_MULT_PIPE_EN (used by cmul_seq_ctrl; DRAIN is only
// reachable when it is defined).
package cmul_pkg;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 2 * W;

    typedef enum logic [2:0] {
        StIdle,
        StMul0,
        StMul1,
        StMul2,
        StMul3,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/cmul_seq_ctrl_if.sv
// Operand / result handshake bundle for cmul_seq_ctrl.
//   in_valid, in_ready        operand handshake
//   ar, ai, br, bi  [W-1:0]   operand A / B, real and imaginary, unsigned
//   out_valid, out_ready      result handshake
//   pr, pi         [PW-1:0]   real / imaginary result, mod 2^PW
//   pr_borrow                 ar*br < ai*bi (pr wrapped)
//   pi_carry                  carry out of ar*bi + ai*br
// Modports: master = operand source / result sink, slave = the controller.
interface cmul_seq_ctrl_if
    import cmul_pkg::*;
();

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ar;
    logic [W-1:0]  ai;
    logic [W-1:0]  br;
    logic [W-1:0]  bi;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] pr;
    logic [PW-1:0] pi;
    logic          pr_borrow;
    logic          pi_carry;

    modport master (
        output in_valid, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, pr, pi, pr_borrow, pi_carry
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, pr, pi, pr_borrow, pi_carry
    );

endinterface

// File: rtl/vedic32.sv
// 32x32 unsigned multiplier, Urdhva-Tiryagbhyam (vertical and crosswise)
// structure over 8-bit digits: each of the seven digit columns sums the
// cross products whose digit indices add up to the column index, then the
// columns are weighted by 2^(8*k) and summed. Purely combinational.
//   a  [31:0]  multiplicand
//   b  [31:0]  multiplier
//   p  [63:0]  full product a*b
module vedic32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    logic [63:0] sum;
    logic [17:0] col;
    logic [15:0] pp;

    always_comb begin
        sum = '0;
        col = '0;
        pp  = '0;
        for (int k = 0; k < 7; k++) begin
            col = '0;
            for (int i = 0; i < 4; i++) begin
                if ((k - i) >= 0 && (k - i) < 4) begin
                    pp  = {8'b0, a[8*i +: 8]} * {8'b0, b[8*(k-i) +: 8]};
                    // Four 16-bit digit products fit in 18 bits.
                    col = col + {2'b0, pp};
                end
            end
            sum = sum + ({46'b0, col} << (8 * k));
        end
    end

    assign p = sum;

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Sequenced complex multiplier controller. Computes
//   pr = ar*br - ai*bi  and  pi = ar*bi + ai*br  (both mod 2^PW)
// by time-sharing one vedic32 multiplier over the four partial products.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cmul_seq_ctrl_if.slave: operand and result valid/ready handshakes
// Parameters: W (must be 32), PW = 2*W (derived).
// Build option CMUL_SEQ_MULT_PIPE_EN: registers the multiplier output, so
// each accumulate lands one cycle after its MULx state and a DRAIN state
// follows MUL3 (one extra cycle of latency and period; same arithmetic).
module cmul_seq_ctrl
    import cmul_pkg::*;
#(
    parameter int unsigned W  = cmul_pkg::W,
    parameter int unsigned PW = 2 * W
) (
    input logic            clk,
    input logic            rst_n,
    cmul_seq_ctrl_if.slave bus
);

    state_e        state_q;
    state_e        state_d;

    logic [W-1:0]  ar_q;
    logic [W-1:0]  ai_q;
    logic [W-1:0]  br_q;
    logic [W-1:0]  bi_q;

    logic [PW-1:0] acc_r_q;
    logic [PW-1:0] acc_i_q;
    logic          pr_borrow_q;
    logic          pi_carry_q;

    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [PW-1:0] mul_p;

    // Which partial product is being folded into the accumulators this
    // cycle, and its value.
    state_e        acc_phase;
    logic [PW-1:0] acc_prod;

    logic [PW:0]   sub_full;
    logic [PW:0]   add_full;
    logic          accept;

    assign accept = (state_q == StIdle) && bus.in_valid;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StMul0;
                end
            end
            StMul0: state_d = StMul1;
            StMul1: state_d = StMul2;
            StMul2: state_d = StMul3;
            StMul3: begin
`ifdef CMUL_SEQ_MULT_PIPE_EN
                state_d = StDrain;
`else
                state_d = StDone;
`endif
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared multiplier; operand selects depend on state only, so there is
    // no combinational path from the bus inputs to any output.
    // ------------------------------------------------------------------
    always_comb begin
        mul_a = ar_q;
        mul_b = br_q;
        case (state_q)
            StMul1: begin
                mul_a = ai_q;
                mul_b = bi_q;
            end
            StMul2: begin
                mul_a = ar_q;
                mul_b = bi_q;
            end
            StMul3: begin
                mul_a = ai_q;
                mul_b = br_q;
            end
            default: ;
        endcase
    end

    vedic32 u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

`ifdef CMUL_SEQ_MULT_PIPE_EN
    logic [PW-1:0] mul_q;
    state_e        phase_q;

    // The product and the state that produced it travel together, so the
    // accumulate step is simply delayed by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_q   <= '0;
            phase_q <= StIdle;
        end else begin
            mul_q   <= mul_p;
            phase_q <= state_q;
        end
    end

    assign acc_phase = phase_q;
    assign acc_prod  = mul_q;
`else
    assign acc_phase = state_q;
    assign acc_prod  = mul_p;
`endif

    // 65-bit add/sub so the top bit is the borrow / carry out.
    assign sub_full = {1'b0, acc_r_q} - {1'b0, acc_prod};
    assign add_full = {1'b0, acc_i_q} + {1'b0, acc_prod};

    // ------------------------------------------------------------------
    // Operand latches and accumulators. pr/pi are not cleared on leaving
    // DONE; they hold the last result until the next sequence overwrites.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            pr_borrow_q <= 1'b0;
            pi_carry_q  <= 1'b0;
        end else begin
            if (accept) begin
                ar_q <= bus.ar;
                ai_q <= bus.ai;
                br_q <= bus.br;
                bi_q <= bus.bi;
            end
            case (acc_phase)
                StMul0: acc_r_q <= acc_prod;
                StMul1: begin
                    acc_r_q     <= sub_full[PW-1:0];
                    pr_borrow_q <= sub_full[PW];
                end
                StMul2: acc_i_q <= acc_prod;
                StMul3: begin
                    acc_i_q    <= add_full[PW-1:0];
                    pi_carry_q <= add_full[PW];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.pr        = acc_r_q;
    assign bus.pi        = acc_i_q;
    assign bus.pr_borrow = pr_borrow_q;
    assign bus.pi_carry  = pi_carry_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Bench for cmul_seq_ctrl: directed and $urandom operands checked against a
// plain-arithmetic complex-product model. Honours CMUL_SEQ_MULT_PIPE_EN.
module tb_cmul_seq_ctrl;

`ifdef CMUL_SEQ_MULT_PIPE_EN
    localparam int LAT    = 6;
    localparam int PERIOD = 7;
`else
    localparam int LAT    = 5;
    localparam int PERIOD = 6;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc   = 0;

    logic [63:0] e_pr, e_pi;
    logic        e_b, e_c;
    int          t_acc;

    logic [31:0] tp_op [4][4];
    logic [63:0] tp_pr [4];
    logic [63:0] tp_pi [4];
    logic        tp_b  [4];
    logic        tp_c  [4];
    int          tp_cyc[4];
    int          n_iss, n_got;
    bit          just_acc;

    cmul_seq_ctrl_if bus ();

    cmul_seq_ctrl #(
        .W  (32),
        .PW (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Complex product straight from the definition.
    task automatic model(input logic [31:0] a_r, a_i, b_r, b_i,
                         output logic [63:0] m_pr, m_pi, output logic m_b, m_c);
        logic [63:0] p_rr, p_ii, p_ri, p_ir;
        logic [64:0] s;
        p_rr = 64'(a_r) * 64'(b_r);
        p_ii = 64'(a_i) * 64'(b_i);
        p_ri = 64'(a_r) * 64'(b_i);
        p_ir = 64'(a_i) * 64'(b_r);
        m_pr = p_rr - p_ii;
        m_b  = (p_rr < p_ii);
        s    = 65'(p_ri) + 65'(p_ir);
        m_pi = s[63:0];
        m_c  = s[64];
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r = r & 32'h0000_00ff;
            1: r = r | 32'hffff_0000;
            default: ;
        endcase
        return r;
    endfunction

    // Present operands, wait for acceptance, scramble inputs afterwards.
    // Returns the accept edge index (cyc value just after that edge).
    task automatic start_op(input logic [31:0] a_r, a_i, b_r, b_i, input string tag,
                            output int t);
        bit seen;
        @(negedge clk);
        bus.ar = a_r; bus.ai = a_i; bus.br = b_r; bus.bi = b_i;
        bus.in_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ":accepted"}, 64'(seen), 64'd1);
        t = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ar = $urandom; bus.ai = $urandom; bus.br = $urandom; bus.bi = $urandom;
        chk({tag, ":busy_in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_done(input int t, input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ":out_valid_seen"}, 64'(seen), 64'd1);
        chk({tag, ":latency"}, 64'(cyc + 1 - t), 64'(LAT));
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ":pr"}, bus.pr, e_pr);
        chk({tag, ":pi"}, bus.pi, e_pi);
        chk({tag, ":pr_borrow"}, 64'(bus.pr_borrow), 64'(e_b));
        chk({tag, ":pi_carry"}, 64'(bus.pi_carry), 64'(e_c));
    endtask

    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ":out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ":idle_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ":pr_held"}, bus.pr, e_pr);
    endtask

    task automatic run_op(input logic [31:0] a_r, a_i, b_r, b_i, input string tag);
        int t;
        model(a_r, a_i, b_r, b_i, e_pr, e_pi, e_b, e_c);
        start_op(a_r, a_i, b_r, b_i, tag, t);
        wait_done(t, tag);
        chk_result(tag);
        finish_op(tag);
    endtask

    task automatic load_tp(input int n);
        for (int j = 0; j < 4; j++) tp_op[n][j] = rnd32();
        model(tp_op[n][0], tp_op[n][1], tp_op[n][2], tp_op[n][3],
              tp_pr[n], tp_pi[n], tp_b[n], tp_c[n]);
        bus.ar = tp_op[n][0]; bus.ai = tp_op[n][1];
        bus.br = tp_op[n][2]; bus.bi = tp_op[n][3];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ar = '0; bus.ai = '0; bus.br = '0; bus.bi = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst:in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst:pr", bus.pr, 64'd0);
        chk("rst:pi", bus.pi, 64'd0);
        chk("rst:flags", {62'd0, bus.pr_borrow, bus.pi_carry}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Small operands, negative real part
        run_op(32'd3, 32'd4, 32'd5, 32'd6, "small");
        chk("small:pr_const", bus.pr, 64'hFFFF_FFFF_FFFF_FFF7);
        chk("small:pi_const", bus.pi, 64'h26);

        // All-ones operands
        run_op('1, '1, '1, '1, "ones");
        chk("ones:pi_const", bus.pi, 64'hFFFF_FFFC_0000_0002);

        // Equal cross products from different operands: zero, no borrow
        run_op(32'd2, 32'd3, 32'd6, 32'd4, "eq");

        // Random operands
        for (int i = 0; i < 4; i++) run_op(rnd32(), rnd32(), rnd32(), rnd32(), "rand");

        // Output stall with in_valid toggling
        model(32'hdead_beef, 32'h1234_5678, 32'h8765_4321, 32'hcafe_f00d, e_pr, e_pi, e_b, e_c);
        start_op(32'hdead_beef, 32'h1234_5678, 32'h8765_4321, 32'hcafe_f00d, "stall", t_acc);
        wait_done(t_acc, "stall");
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.ar = $urandom; bus.ai = $urandom; bus.br = $urandom; bus.bi = $urandom;
            @(negedge clk);
            chk("stall:out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall:in_ready", 64'(bus.in_ready), 64'd0);
            chk_result("stall");
        end
        bus.in_valid = 1'b0;
        finish_op("stall");

        // Back-to-back throughput
        bus.out_ready = 1'b1;
        n_iss = 0;
        n_got = 0;
        @(negedge clk);
        load_tp(0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (n_got == 4) break;
            if (bus.out_valid) begin
                chk("tp:pr", bus.pr, tp_pr[n_got]);
                chk("tp:pi", bus.pi, tp_pi[n_got]);
                chk("tp:pr_borrow", 64'(bus.pr_borrow), 64'(tp_b[n_got]));
                chk("tp:pi_carry", 64'(bus.pi_carry), 64'(tp_c[n_got]));
                n_got++;
            end
            just_acc = bus.in_valid && bus.in_ready;
            if (just_acc && n_iss < 4) begin
                tp_cyc[n_iss] = cyc + 1;
                n_iss++;
            end
            @(negedge clk);
            if (just_acc) begin
                if (n_iss < 4) load_tp(n_iss);
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("tp:results", 64'(n_got), 64'd4);
        chk("tp:issued", 64'(n_iss), 64'd4);
        for (int i = 1; i < 4; i++) begin
            chk("tp:period", 64'(tp_cyc[i] - tp_cyc[i-1]), 64'(PERIOD));
        end

        // Reset during MUL2
        start_op(32'h0101_0101, 32'h7, 32'h9, 32'hffff_0000, "midrst", t_acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst:pr", bus.pr, 64'd0);
        chk("midrst:pi", bus.pi, 64'd0);
        chk("midrst:flags", {62'd0, bus.pr_borrow, bus.pi_carry}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(rnd32(), rnd32(), rnd32(), rnd32(), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
